// File: rtl/spongent_pkg.sv
// rtl/spongent_pkg.sv - shared state encodings and constants for the SPONGENT sequencer
package spongent_pkg;

  typedef enum logic [6:0] {
    IDLE      = 7'b000_0001,
    COLLECT   = 7'b000_0010,
    ISSUE     = 7'b000_0100,
    WAIT_ACK  = 7'b000_1000,
    WAIT_DONE = 7'b001_0000,
    SQ_LOAD   = 7'b010_0000,
    SQ_OUT    = 7'b100_0000
  } state_e;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic int bytes_per_block(input int rate);
    return rate / 8;
  endfunction

endpackage

// File: rtl/spongent_sequencer_if.sv
// rtl/spongent_sequencer_if.sv - host-side byte streams and control of the sequencer
interface spongent_sequencer_if;
  logic       start;
  logic       empty;
  logic       msg_valid;
  logic [7:0] msg_data;
  logic       msg_last;
  logic       msg_ready;
  logic       dig_valid;
  logic [7:0] dig_data;
  logic       dig_last;
  logic       dig_ready;
  logic       busy;

  modport master (
    output start, empty, msg_valid, msg_data, msg_last, dig_ready,
    input  msg_ready, dig_valid, dig_data, dig_last, busy
  );

  modport slave (
    input  start, empty, msg_valid, msg_data, msg_last, dig_ready,
    output msg_ready, dig_valid, dig_data, dig_last, busy
  );
endinterface

// File: rtl/spongent_byte_packer.sv
// rtl/spongent_byte_packer.sv - places message bytes MSB-first into a rate block with sponge padding
module spongent_byte_packer
  import spongent_pkg::*;
#(
  parameter int RATE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            load_pad_i,
  input  logic            push_i,
  input  logic [7:0]      byte_i,
  input  logic            last_i,
  output logic [RATE-1:0] block_o,
  output logic            last_slot_o
);
  localparam int NB = bytes_per_block(RATE);
  localparam int CW = $clog2(NB + 1);

  logic [RATE-1:0] block_q, block_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Block is cleared before collecting, so padding only needs the 0x80 marker.
  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      block_d = '0;
      cnt_d   = '0;
    end else if (load_pad_i) begin
      block_d = '0;
      block_d[RATE-1 -: 8] = PAD_BYTE;
      cnt_d   = '0;
    end else if (push_i) begin
      for (int i = 0; i < NB; i++) begin
        if (cnt_q == CW'(i)) block_d[RATE-1-8*i -: 8] = byte_i;
      end
      for (int i = 1; i < NB; i++) begin
        if (last_i && cnt_q == CW'(i - 1)) block_d[RATE-1-8*i -: 8] = PAD_BYTE;
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign block_o     = block_q;
  assign last_slot_o = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/spongent_sequencer.sv
// rtl/spongent_sequencer.sv - absorbs a byte stream into the SPONGENT core and squeezes the digest out
module spongent_sequencer
  import spongent_pkg::*;
#(
  parameter int RATE      = 16,
  parameter int HASH_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  spongent_sequencer_if.slave  host,
  output logic                 core_start,
  output logic                 core_msg_avail,
  output logic [RATE-1:0]      core_msg_data,
  input  logic                 core_busy,
  input  logic [RATE-1:0]      core_rate
);
  localparam int NB   = bytes_per_block(RATE);
  localparam int OCW  = $clog2(NB + 1);
  localparam int NBLK = HASH_BITS / RATE;
  localparam int BW   = $clog2(NBLK + 1);

  state_e          state_q;
  logic            busy_q, core_start_q, core_avail_q, msg_ready_q;
  logic            dig_valid_q, dig_last_q;
  logic [RATE-1:0] out_q;
  logic [OCW-1:0]  out_cnt_q;
  logic [BW-1:0]   sq_blk_q;
  logic            squeezing_q, pad_pending_q, final_q;

  logic start_go, push, core_done, next_collect, pad_go, pk_clear, pk_load_pad;
  logic last_slot, sq_last_blk;

  assign start_go     = (state_q == IDLE) && host.start;
  assign push         = (state_q == COLLECT) && host.msg_valid;
  assign core_done    = (state_q == WAIT_DONE) && !core_busy;
  assign next_collect = core_done && !squeezing_q && !pad_pending_q && !final_q;
  assign pad_go       = core_done && !squeezing_q && pad_pending_q;
  assign pk_clear     = (start_go && !host.empty) || next_collect;
  assign pk_load_pad  = (start_go && host.empty) || pad_go;
  assign sq_last_blk  = (sq_blk_q == BW'(NBLK - 1));

  spongent_byte_packer #(.RATE(RATE)) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .load_pad_i  (pk_load_pad),
    .push_i      (push),
    .byte_i      (host.msg_data),
    .last_i      (host.msg_last),
    .block_o     (core_msg_data),
    .last_slot_o (last_slot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      core_start_q  <= 1'b0;
      core_avail_q  <= 1'b0;
      msg_ready_q   <= 1'b0;
      dig_valid_q   <= 1'b0;
      dig_last_q    <= 1'b0;
      out_q         <= '0;
      out_cnt_q     <= '0;
      sq_blk_q      <= '0;
      squeezing_q   <= 1'b0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host.start) begin
            busy_q        <= 1'b1;
            final_q       <= host.empty;
            pad_pending_q <= 1'b0;
            squeezing_q   <= 1'b0;
            sq_blk_q      <= '0;
            if (host.empty) begin
              state_q      <= ISSUE;
              core_start_q <= 1'b1;
              core_avail_q <= 1'b1;
            end else begin
              state_q     <= COLLECT;
              msg_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (host.msg_valid) begin
            if (host.msg_last || last_slot) begin
              state_q      <= ISSUE;
              msg_ready_q  <= 1'b0;
              core_start_q <= 1'b1;
              core_avail_q <= 1'b1;
            end
            if (host.msg_last) begin
              final_q       <= 1'b1;
              pad_pending_q <= last_slot;
            end
          end
        end
        ISSUE: begin
          core_avail_q <= 1'b0;
          state_q      <= WAIT_ACK;
        end
        // The core raises busy a cycle late, so it is not looked at here.
        WAIT_ACK: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (!core_busy) begin
            if (squeezing_q || (final_q && !pad_pending_q)) begin
              state_q     <= SQ_LOAD;
              squeezing_q <= 1'b1;
            end else if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
              state_q       <= ISSUE;
              core_start_q  <= 1'b1;
              core_avail_q  <= 1'b1;
            end else begin
              state_q     <= COLLECT;
              msg_ready_q <= 1'b1;
            end
          end
        end
        SQ_LOAD: begin
          out_q       <= core_rate;
          out_cnt_q   <= OCW'(NB);
          dig_valid_q <= 1'b1;
          dig_last_q  <= (NB == 1) && sq_last_blk;
          state_q     <= SQ_OUT;
        end
        SQ_OUT: begin
          if (host.dig_ready) begin
            if (out_cnt_q != OCW'(1)) begin
              out_q      <= out_q << 8;
              out_cnt_q  <= out_cnt_q - OCW'(1);
              dig_last_q <= (out_cnt_q == OCW'(2)) && sq_last_blk;
            end else begin
              dig_valid_q <= 1'b0;
              dig_last_q  <= 1'b0;
              if (sq_last_blk) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                sq_blk_q     <= sq_blk_q + BW'(1);
                core_start_q <= 1'b1;
                state_q      <= WAIT_ACK;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host.msg_ready = msg_ready_q;
  assign host.dig_valid = dig_valid_q;
  assign host.dig_data  = out_q[RATE-1 -: 8];
  assign host.dig_last  = dig_last_q;
  assign host.busy      = busy_q;
  assign core_start     = core_start_q;
  assign core_msg_avail = core_avail_q;

endmodule

// File: tb/tb_spongent_sequencer.sv
// tb/tb_spongent_sequencer.sv - randomized self-checking bench for spongent_sequencer
module tb_spongent_sequencer;
  localparam int RATE      = 16;
  localparam int HASH_BITS = 32;
  localparam int NB        = RATE / 8;
  localparam int NBLK      = HASH_BITS / RATE;
  localparam int TOTAL     = HASH_BITS / 8;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            core_start, core_msg_avail;
  logic [RATE-1:0] core_msg_data;
  logic            core_busy = 1'b0;
  logic [RATE-1:0] core_rate = '0;

  spongent_sequencer_if sif ();

  spongent_sequencer #(.RATE(RATE), .HASH_BITS(HASH_BITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (sif),
    .core_start     (core_start),
    .core_msg_avail (core_msg_avail),
    .core_msg_data  (core_msg_data),
    .core_busy      (core_busy),
    .core_rate      (core_rate)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stab_err, stall_err, proto_err;
  int lat_fixed = 0;

  logic [7:0]      msg_q[$];
  logic [7:0]      dig_bytes[$];
  logic            dig_lasts[$];
  logic            log_avail[$];
  logic [RATE-1:0] log_data[$];
  logic [RATE-1:0] rate_log[$];
  logic [RATE-1:0] fixed_rates[$];

  // Core model: busy rises the cycle after a request and stays high for lat cycles.
  int dly = 0, cnt = 0;
  logic [RATE-1:0] cur_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      core_busy = 1'b0;
      dly = 0;
      cnt = 0;
    end else begin
      if (core_busy) begin
        if (core_msg_data !== cur_data) stab_err++;
        cnt--;
        if (cnt <= 0) begin
          core_busy = 1'b0;
          if (fixed_rates.size() > 0) core_rate = fixed_rates.pop_front();
          else core_rate = RATE'($urandom);
          rate_log.push_back(core_rate);
        end
      end else if (dly > 0) begin
        if (core_msg_data !== cur_data) stab_err++;
        dly--;
        if (dly == 0) begin
          core_busy = 1'b1;
          cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 20));
        end
      end
      if (core_start === 1'b1) begin
        log_avail.push_back(core_msg_avail);
        log_data.push_back(core_msg_data);
        cur_data = core_msg_data;
        dly = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_msg_ready"}, 32'(sif.msg_ready), 32'd0);
    chk({pfx, "_dig_valid"}, 32'(sif.dig_valid), 32'd0);
    chk({pfx, "_dig_data"}, 32'(sif.dig_data), 32'd0);
    chk({pfx, "_dig_last"}, 32'(sif.dig_last), 32'd0);
    chk({pfx, "_busy"}, 32'(sif.busy), 32'd0);
    chk({pfx, "_core_start"}, 32'(core_start), 32'd0);
    chk({pfx, "_core_msg_avail"}, 32'(core_msg_avail), 32'd0);
    chk({pfx, "_core_msg_data"}, 32'(core_msg_data), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    sif.empty = (msg_q.size() == 0);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.empty = 1'b0;
  endtask

  task automatic send_msg();
    int t;
    for (int i = 0; i < msg_q.size(); i++) begin
      sif.msg_valid = 1'b0;
      while ($urandom_range(0, 3) == 0) @(negedge clk);
      sif.msg_valid = 1'b1;
      sif.msg_data  = msg_q[i];
      sif.msg_last  = (i == msg_q.size() - 1);
      t = 0;
      while (!sif.msg_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) proto_err++;
      @(negedge clk);
    end
    sif.msg_valid = 1'b0;
    sif.msg_last  = 1'b0;
  endtask

  task automatic collect_digest(input bit poke);
    int cyc = 0;
    logic pv = 1'b0, pa = 1'b0;
    logic [7:0] pd = '0;
    dig_bytes.delete();
    dig_lasts.delete();
    while (dig_bytes.size() < TOTAL && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      sif.start = poke && (cyc == 3);
      if (pv && !pa && (sif.dig_valid !== 1'b1 || sif.dig_data !== pd)) stall_err++;
      if (sif.msg_ready !== 1'b0) proto_err++;
      sif.dig_ready = ($urandom_range(0, 2) != 0);
      pv = sif.dig_valid;
      pd = sif.dig_data;
      pa = pv && sif.dig_ready;
      if (pa) begin
        dig_bytes.push_back(sif.dig_data);
        dig_lasts.push_back(sif.dig_last);
      end
    end
    @(negedge clk);
    sif.dig_ready = 1'b0;
    sif.start     = 1'b0;
    chk("busy_after_digest", 32'(sif.busy), 32'd0);
    chk("valid_after_digest", 32'(sif.dig_valid), 32'd0);
  endtask

  task automatic run_hash(input bit poke);
    logic [7:0]      pb[$];
    logic [RATE-1:0] eb[$];
    logic [7:0]      ed[$];
    logic [RATE-1:0] w;
    int nb;
    log_avail.delete();
    log_data.delete();
    rate_log.delete();
    stab_err = 0;
    stall_err = 0;
    proto_err = 0;
    // Sponge padding: append 0x80, then zeros up to a whole block.
    pb = msg_q;
    pb.push_back(8'h80);
    while (pb.size() % NB != 0) pb.push_back(8'h00);
    nb = pb.size() / NB;
    for (int b = 0; b < nb; b++) begin
      w = '0;
      for (int k = 0; k < NB; k++) w = (w << 8) | RATE'(pb[b*NB+k]);
      eb.push_back(w);
    end
    do_start();
    send_msg();
    collect_digest(poke);
    chk("n_core_start", 32'(log_avail.size()), 32'(nb + NBLK - 1));
    for (int i = 0; i < log_avail.size() && i < nb + NBLK - 1; i++) begin
      chk("msg_avail", 32'(log_avail[i]), (i < nb) ? 32'd1 : 32'd0);
      if (i < nb) chk("absorb_block", 32'(log_data[i]), 32'(eb[i]));
    end
    chk("n_rates", 32'(rate_log.size()), 32'(nb + NBLK - 1));
    for (int j = rate_log.size() - NBLK; j < rate_log.size(); j++) begin
      if (j >= 0) begin
        for (int k = NB - 1; k >= 0; k--) ed.push_back(8'(rate_log[j] >> (8 * k)));
      end
    end
    chk("n_dig_bytes", 32'(dig_bytes.size()), 32'(TOTAL));
    for (int i = 0; i < dig_bytes.size() && i < ed.size(); i++) begin
      chk("dig_data", 32'(dig_bytes[i]), 32'(ed[i]));
      chk("dig_last", 32'(dig_lasts[i]), 32'(i == TOTAL - 1));
    end
    chk("stall_hold", 32'(stall_err), 32'd0);
    chk("protocol", 32'(proto_err), 32'd0);
    chk("msg_data_stable", 32'(stab_err), 32'd0);
  endtask

  task automatic random_msg();
    int n;
    msg_q.delete();
    n = $urandom_range(0, 7);
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    int t;
    logic [7:0] ord[4];
    sif.start = 1'b0;
    sif.empty = 1'b0;
    sif.msg_valid = 1'b0;
    sif.msg_data = '0;
    sif.msg_last = 1'b0;
    sif.dig_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    lat_fixed = 20;
    msg_q.delete();
    fixed_rates = '{16'h1234, 16'h5678};
    run_hash(1'b0);
    ord = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4 && i < dig_bytes.size(); i++) chk("digest_order", 32'(dig_bytes[i]), 32'(ord[i]));

    lat_fixed = 0;
    msg_q = '{8'hA1};
    run_hash(1'b0);
    if (log_data.size() > 0) chk("one_byte_block", 32'(log_data[0]), 32'h0000A180);

    lat_fixed = 20;
    msg_q = '{8'hA1, 8'hB2};
    run_hash(1'b1);
    if (log_data.size() > 1) begin
      chk("full_block", 32'(log_data[0]), 32'h0000A1B2);
      chk("extra_pad_block", 32'(log_data[1]), 32'h00008000);
    end

    lat_fixed = 0;
    for (int r = 0; r < 8; r++) begin
      random_msg();
      run_hash(r[0]);
    end

    lat_fixed = 20;
    msg_q = '{8'h11, 8'h22};
    do_start();
    send_msg();
    t = 0;
    while (!core_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_wait_done", 32'(core_busy), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    log_avail.delete();
    log_data.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_start_after_reset", 32'(log_avail.size()), 32'd0);

    lat_fixed = 0;
    for (int r = 0; r < 2; r++) begin
      random_msg();
      run_hash(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spongent_sequencer.md
Name: spongent_sequencer

Overview:
- Drives the SPONGENT control FSM from the host side: packs a byte stream into rate-wide blocks, applies sponge padding, absorbs, then squeezes the digest out as a byte stream.
- Sits between the crypto unit's byte-level host interface and the SPONGENT core's start_continue / msg_data_available / busy interface.
- The core computes all permutation rounds; this block only issues requests and samples the rate portion of the state.

Parameters:
- RATE, 16: sponge rate in bits; multiple of 8, at least 8.
- HASH_BITS, 128: digest length in bits; multiple of RATE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a new hash; ignored unless busy=0
- empty  in  1  sampled with start; 1 = zero-length message
- msg_valid  in  1  message byte valid
- msg_data  in  8  message byte
- msg_last  in  1  marks the final message byte
- msg_ready  out  1  byte accepted when msg_valid & msg_ready
- dig_valid  out  1  digest byte valid
- dig_data  out  8  digest byte, most significant byte first
- dig_last  out  1  marks the final digest byte
- dig_ready  in  1  consumer accepts the digest byte
- busy  out  1  high from an accepted start until the last digest byte is accepted
- core_start  out  1  to the core's start_continue; one-cycle pulse
- core_msg_avail  out  1  to the core's msg_data_available; 1 = absorb, 0 = squeeze permutation
- core_msg_data  out  RATE  block XORed into the state; held stable from core_start until core_busy falls
- core_busy  in  1  core busy
- core_rate  in  RATE  rate part of the core state, valid while core_busy=0

Behaviour:
- Reset: every output is 0. The FSM is in IDLE. The block buffer and byte counter are cleared. Reset mid-operation aborts immediately, with no further core_start.
- States:
  - IDLE
  - COLLECT
  - ISSUE
  - WAIT_ACK
  - WAIT_DONE
  - SQ_LOAD
  - SQ_OUT
- IDLE:
  - start=1 with empty=0 goes to COLLECT.
  - start=1 with empty=1 loads the pad block {8'h80, zeros} and goes to ISSUE.
- COLLECT:
  - msg_ready=1.
  - Each accepted byte is shifted in; the first byte lands in bits [RATE-1:RATE-8].
  - Block full and msg_last=0: go to ISSUE.
  - msg_last=1 with the block not full: fill the remaining bytes with 0x80 then 0x00, and go to ISSUE. This is the final block.
  - msg_last=1 exactly filling the block: go to ISSUE, then add one extra pad block {0x80, zeros}.
- ISSUE:
  - core_start=1 and core_msg_avail=1 for exactly one cycle.
  - Next state is WAIT_ACK.
- WAIT_ACK:
  - Lasts exactly one cycle; core_busy is ignored, because the core registers busy one cycle after the request.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - Wait for core_busy=0.
  - If more message remains, go to COLLECT.
  - If another block (pad) is pending, go to ISSUE.
  - After the final absorb, go to SQ_LOAD.
  - After a squeeze permutation, go to SQ_LOAD.
- SQ_LOAD:
  - Capture core_rate into the output shift register and set the byte count to RATE/8.
  - Next state is SQ_OUT.
- SQ_OUT:
  - dig_valid=1 and dig_data = top byte; shift on dig_valid & dig_ready.
  - dig_last=1 on the final byte of the final block.
  - When a block is exhausted and more digest is needed: pulse core_start with core_msg_avail=0, go to WAIT_ACK, then WAIT_DONE.
  - After the last byte is accepted: go to IDLE and drop busy in that same clock edge.
- Counters: a squeeze-block counter counts HASH_BITS/RATE blocks, with no permutation after the last block.
- Latency: a squeeze permutation is issued 1 cycle after the last byte of a block is accepted.
- Boundaries:
  - dig_ready stalls hold dig_data stable indefinitely.
  - msg_valid low in COLLECT stalls without timeout.
  - start while busy=1 is ignored.
  - msg_valid outside COLLECT is not accepted (msg_ready=0).
  - core_busy=1 outside WAIT_DONE is ignored.

Decomposition:
- Shared package (spongent_pkg): the state encodings (one-hot, matching the core FSM style), the PAD_BYTE=8'h80 constant, and a function computing the number of bytes per block.
- One natural sub-module, spongent_byte_packer: the byte shift-in, padding fill and full/last flags. Block-in and block-out stay in the top level.

Test Plan:
- Empty message (RATE=16, HASH_BITS=32): start with empty=1 -> one absorb with core_msg_data=16'h8000 and core_msg_avail=1, then 1 squeeze permutation; 4 digest bytes, dig_last on the 4th; busy falls after it.
- Message 0xA1 then msg_last -> core_msg_data=16'hA180. Message 0xA1,0xB2 then msg_last -> blocks 16'hA1B2, then 16'h8000.
- Core model holding core_busy high for 20 cycles, rising 1 cycle after core_start -> exactly one core_start per block; core_msg_data stable throughout.
- Digest ordering: core_rate=16'h1234 then 16'h5678 -> dig_data sequence 0x12, 0x34, 0x56, 0x78. Random dig_ready stalls hold dig_data.
- Reset asserted in WAIT_DONE -> all outputs 0 asynchronously; a new hash afterwards completes correctly.
- start pulsed while busy=1 -> ignored; digest of the first hash unaffected.
